// File: rtl/cart_mmc1.sv
// MMC1-class (SxROM) cartridge mapper: serial-loaded bank/mode registers,
// banked PRG/CHR addressing, read-data gating and run-time mirroring.
module cart_mmc1 #(
    parameter int PRG_AW  = 18,
    parameter int CHR_AW  = 17,
    parameter int CHR_RAM = 0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              prg_nce_in,
    input  logic [14:0]       prg_a_in,
    input  logic              prg_r_nw_in,
    input  logic [7:0]        prg_d_in,
    output logic [7:0]        prg_d_out,
    output logic [PRG_AW-1:0] prg_mem_a_out,
    input  logic [7:0]        prg_mem_d_in,
    input  logic [13:0]       chr_a_in,
    input  logic              chr_r_nw_in,
    input  logic [7:0]        chr_d_in,
    output logic [7:0]        chr_d_out,
    output logic [CHR_AW-1:0] chr_mem_a_out,
    input  logic [7:0]        chr_mem_d_in,
    output logic              chr_mem_we_out,
    output logic              ciram_nce_out,
    output logic              ciram_a10_out
);

    logic [4:0]  sr;
    logic [2:0]  cnt;
    logic [4:0]  ctl;
    logic [4:0]  chr0;
    logic [4:0]  chr1;
    logic [3:0]  prg;
    logic        wr_q;

    logic        wa;
    logic        ev;
    logic [4:0]  v;
    logic [3:0]  prg_bank;
    logic [4:0]  chr_bank;
    logic [17:0] prg_full;
    logic [16:0] chr_full;
    logic        unused;

    // A write held over several cycles is only counted on its first cycle
    assign wa = ~prg_nce_in & ~prg_r_nw_in;
    assign ev = wa & ~wr_q;
    assign v  = {prg_d_in[0], sr[4:1]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sr   <= 5'd0;
            cnt  <= 3'd0;
            ctl  <= 5'h0C;
            chr0 <= 5'd0;
            chr1 <= 5'd0;
            prg  <= 4'd0;
            wr_q <= 1'b0;
        end else begin
            wr_q <= wa;
            if (ev) begin
                if (prg_d_in[7]) begin
                    sr  <= 5'd0;
                    cnt <= 3'd0;
                    ctl <= ctl | 5'h0C;
                end else if (cnt != 3'd4) begin
                    sr  <= v;
                    cnt <= cnt + 3'd1;
                end else begin
                    unique case (prg_a_in[14:13])
                        2'd0: ctl  <= v;
                        2'd1: chr0 <= v;
                        2'd2: chr1 <= v;
                        2'd3: prg  <= v[3:0];
                    endcase
                    sr  <= 5'd0;
                    cnt <= 3'd0;
                end
            end
        end
    end

    always_comb begin
        prg_bank = {prg[3:1], prg_a_in[14]};
        unique case (ctl[3:2])
            2'd2:    prg_bank = prg_a_in[14] ? prg : 4'd0;
            2'd3:    prg_bank = prg_a_in[14] ? 4'hF : prg;
            default: prg_bank = {prg[3:1], prg_a_in[14]};
        endcase
    end

    always_comb begin
        chr_bank = {chr0[4:1], chr_a_in[12]};
        if (ctl[4]) begin
            chr_bank = chr_a_in[12] ? chr1 : chr0;
        end
    end

    always_comb begin
        ciram_a10_out = 1'b0;
        unique case (ctl[1:0])
            2'd0: ciram_a10_out = 1'b0;
            2'd1: ciram_a10_out = 1'b1;
            2'd2: ciram_a10_out = chr_a_in[10];
            2'd3: ciram_a10_out = chr_a_in[11];
        endcase
    end

    // Full-width addresses are truncated, so bank numbers wrap naturally
    assign prg_full      = {prg_bank, prg_a_in[13:0]};
    assign chr_full      = {chr_bank, chr_a_in[11:0]};
    assign prg_mem_a_out = prg_full[PRG_AW-1:0];
    assign chr_mem_a_out = chr_full[CHR_AW-1:0];

    assign prg_d_out      = prg_mem_d_in & {8{~prg_nce_in}};
    assign chr_d_out      = chr_mem_d_in & {8{~chr_a_in[13]}};
    assign chr_mem_we_out = (CHR_RAM != 0) & ~chr_a_in[13] & ~chr_r_nw_in;
    assign ciram_nce_out  = ~chr_a_in[13];

    assign unused = ^{prg_d_in[6:1], chr_d_in, prg_full, chr_full};

endmodule

// File: tb/tb_cart_mmc1.sv
// Bench for cart_mmc1: directed plan items plus random writes/probes
// checked against a bit-list mapper model.
module tb_cart_mmc1;

    logic        clk_in;
    logic        rst_n_in;
    logic        prg_nce_in;
    logic [14:0] prg_a_in;
    logic        prg_r_nw_in;
    logic [7:0]  prg_d_in;
    logic [7:0]  prg_d_out;
    logic [17:0] prg_mem_a_out;
    logic [7:0]  prg_mem_d_in;
    logic [13:0] chr_a_in;
    logic        chr_r_nw_in;
    logic [7:0]  chr_d_in;
    logic [7:0]  chr_d_out;
    logic [16:0] chr_mem_a_out;
    logic [7:0]  chr_mem_d_in;
    logic        chr_mem_we_out;
    logic        ciram_nce_out;
    logic        ciram_a10_out;

    int checks = 0;
    int failures = 0;

    int m_ctl, m_chr0, m_chr1, m_prg;
    int m_bits[$];
    bit m_wrq;

    cart_mmc1 #(.PRG_AW(18), .CHR_AW(17), .CHR_RAM(0)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .prg_nce_in(prg_nce_in), .prg_a_in(prg_a_in),
        .prg_r_nw_in(prg_r_nw_in), .prg_d_in(prg_d_in),
        .prg_d_out(prg_d_out), .prg_mem_a_out(prg_mem_a_out),
        .prg_mem_d_in(prg_mem_d_in), .chr_a_in(chr_a_in),
        .chr_r_nw_in(chr_r_nw_in), .chr_d_in(chr_d_in),
        .chr_d_out(chr_d_out), .chr_mem_a_out(chr_mem_a_out),
        .chr_mem_d_in(chr_mem_d_in), .chr_mem_we_out(chr_mem_we_out),
        .ciram_nce_out(ciram_nce_out), .ciram_a10_out(ciram_a10_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ctl  = 12;
        m_chr0 = 0;
        m_chr1 = 0;
        m_prg  = 0;
        m_bits.delete();
        m_wrq  = 0;
    endtask

    task automatic m_event(input int a, input int d);
        int v;
        if (d >= 128) begin
            m_bits.delete();
            m_ctl = m_ctl | 12;
        end else begin
            m_bits.push_back(d % 2);
            if (m_bits.size() == 5) begin
                v = 0;
                for (int i = 0; i < 5; i++) v += m_bits[i] << i;
                case ((a >> 13) % 4)
                    0: m_ctl  = v;
                    1: m_chr0 = v;
                    2: m_chr1 = v;
                    default: m_prg = v % 16;
                endcase
                m_bits.delete();
            end
        end
    endtask

    function automatic int exp_prg(input int a);
        int hi, b;
        hi = (a >> 14) % 2;
        case ((m_ctl >> 2) % 4)
            2: b = hi ? m_prg : 0;
            3: b = hi ? 15 : m_prg;
            default: b = (m_prg / 2) * 2 + hi;
        endcase
        return (b * 16384 + a % 16384) % (1 << 18);
    endfunction

    function automatic int exp_chr(input int a);
        int hi, c;
        hi = (a >> 12) % 2;
        if (m_ctl >= 16) c = hi ? m_chr1 : m_chr0;
        else c = (m_chr0 / 2) * 2 + hi;
        return (c * 4096 + a % 4096) % (1 << 17);
    endfunction

    function automatic int exp_a10(input int a);
        case (m_ctl % 4)
            0: return 0;
            1: return 1;
            2: return (a >> 10) % 2;
            default: return (a >> 11) % 2;
        endcase
    endfunction

    // One clock edge with the model following the DUT's event rule
    task automatic step();
        bit wa, ev;
        int a, d;
        wa = !prg_nce_in && !prg_r_nw_in;
        ev = wa && !m_wrq;
        a  = int'(prg_a_in);
        d  = int'(prg_d_in);
        @(posedge clk_in);
        if (rst_n_in) begin
            if (ev) m_event(a, d);
            m_wrq = wa;
        end
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d,
                      input int hold);
        prg_nce_in  = 1'b0;
        prg_r_nw_in = 1'b0;
        prg_a_in    = a;
        prg_d_in    = d;
        repeat (hold) step();
        prg_nce_in  = 1'b1;
        prg_r_nw_in = 1'b1;
        step();
    endtask

    task automatic load5(input logic [14:0] a, input logic [4:0] val);
        for (int i = 0; i < 5; i++) wr(a, {7'd0, val[i]}, 1);
    endtask

    task automatic probe(input logic [14:0] pa, input logic [13:0] ca,
                         input logic pnce, input logic crnw);
        int pd, cd;
        prg_nce_in   = pnce;
        prg_r_nw_in  = 1'b1;
        prg_a_in     = pa;
        chr_a_in     = ca;
        chr_r_nw_in  = crnw;
        chr_d_in     = 8'($urandom);
        prg_mem_d_in = 8'($urandom);
        chr_mem_d_in = 8'($urandom);
        #1;
        pd = pnce ? 0 : int'(prg_mem_d_in);
        cd = ca[13] ? 0 : int'(chr_mem_d_in);
        check("prg_mem_a", int'(prg_mem_a_out), exp_prg(int'(pa)));
        check("chr_mem_a", int'(chr_mem_a_out), exp_chr(int'(ca)));
        check("prg_d", int'(prg_d_out), pd);
        check("chr_d", int'(chr_d_out), cd);
        check("chr_we", int'(chr_mem_we_out), 0);
        check("ciram_nce", int'(ciram_nce_out), ca[13] ? 0 : 1);
        check("ciram_a10", int'(ciram_a10_out), exp_a10(int'(ca)));
        prg_nce_in = 1'b1;
    endtask

    initial begin
        rst_n_in     = 1'b0;
        prg_nce_in   = 1'b1;
        prg_a_in     = '0;
        prg_r_nw_in  = 1'b1;
        prg_d_in     = '0;
        prg_mem_d_in = '0;
        chr_a_in     = '0;
        chr_r_nw_in  = 1'b1;
        chr_d_in     = '0;
        chr_mem_d_in = '0;
        m_reset();
        repeat (2) @(posedge clk_in);
        #1;
        probe(15'h4000, 14'h0000, 1'b0, 1'b1);
        check("rst_c000", int'(prg_mem_a_out), 'h3C000);
        probe(15'h0000, 14'h0000, 1'b0, 1'b1);
        check("rst_8000", int'(prg_mem_a_out), 'h00000);
        rst_n_in = 1'b1;
        step();

        load5(15'h6000, 5'b00101);
        probe(15'h0000, 14'h0123, 1'b0, 1'b1);
        check("prg5_8000", int'(prg_mem_a_out), 'h14000);

        load5(15'h0000, 5'h02);
        probe(15'h1234, 14'h2400, 1'b0, 1'b1);
        check("vert_a10", int'(ciram_a10_out), 1);
        check("vert_nce", int'(ciram_nce_out), 0);
        load5(15'h0000, 5'h03);
        probe(15'h1234, 14'h2400, 1'b1, 1'b1);
        check("horz_a10_0", int'(ciram_a10_out), 0);
        probe(15'h1234, 14'h2800, 1'b1, 1'b1);
        check("horz_a10_1", int'(ciram_a10_out), 1);

        wr(15'h6000, 8'h01, 3);
        wr(15'h6000, 8'h01, 1);
        wr(15'h6000, 8'h00, 1);
        wr(15'h6000, 8'h00, 1);
        wr(15'h6000, 8'h00, 1);
        probe(15'h0000, 14'h0000, 1'b0, 1'b1);
        check("held_wr", int'(prg_mem_a_out), 'h08000);
        for (int i = 0; i < 3; i++) wr(15'h6000, 8'h01, 1);
        wr(15'h6000, 8'h80, 1);
        probe(15'h4000, 14'h0000, 1'b0, 1'b1);
        check("rst_bit_c000", int'(prg_mem_a_out), 'h3C000);

        load5(15'h0000, 5'h10);
        load5(15'h2000, 5'h03);
        load5(15'h4000, 5'h1F);
        probe(15'h0000, 14'h1000, 1'b1, 1'b0);
        check("chr_1000", int'(chr_mem_a_out), 'h1F000);
        check("chr_rom_we", int'(chr_mem_we_out), 0);
        probe(15'h0000, 14'h0000, 1'b1, 1'b0);
        check("chr_0000", int'(chr_mem_a_out), 'h03000);

        for (int i = 0; i < 3; i++) wr(15'h6000, 8'h01, 1);
        rst_n_in = 1'b0;
        #1;
        m_reset();
        probe(15'h4000, 14'h1000, 1'b0, 1'b1);
        check("mid_rst_c000", int'(prg_mem_a_out), 'h3C000);
        check("mid_rst_chr", int'(chr_mem_a_out), 'h01000);
        rst_n_in = 1'b1;
        step();
        load5(15'h6000, 5'b00110);
        probe(15'h0000, 14'h0000, 1'b0, 1'b1);
        check("post_rst_load", int'(prg_mem_a_out), 'h18000);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            d[7] = ($urandom_range(7) == 0);
            wr(15'($urandom), d, int'($urandom_range(1, 3)));
            if ($urandom_range(3) == 0) begin
                probe(15'($urandom), 14'($urandom), 1'($urandom),
                      1'($urandom));
            end
        end
        probe(15'($urandom), 14'($urandom), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cart_mmc1.md
# cart_mmc1

Parametrised successor to the fixed-mapping NROM cartridge: an MMC1-class (SxROM) bank-switching mapper between the CPU/PPU cartridge buses and external synchronous PRG/CHR memories. A 5-write serial load port sets the bank and mode registers. The block drives banked memory addresses, gates read data onto the buses, and selects nametable mirroring at run time. The PRG/CHR memories are instantiated outside the block.

## Interface
- PRG_AW, 18: PRG memory address width; 16 KB banks, 14..18.
- CHR_AW, 17: CHR memory address width; 4 KB banks, 13..17.
- CHR_RAM, 0: 1 means CHR memory is RAM and PPU writes are passed through; 0 means ROM with writes dropped.
- clk_in  in  1  system clock; all state changes on the rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- prg_nce_in  in  1  CPU $8000-$FFFF select, active low.
- prg_a_in  in  15  CPU address.
- prg_r_nw_in  in  1  CPU read=1 / write=0.
- prg_d_in  in  8  CPU write data.
- prg_d_out  out  8  CPU read data; 0 when prg_nce_in=1.
- prg_mem_a_out  out  PRG_AW  banked PRG memory address.
- prg_mem_d_in  in  8  PRG memory read data.
- chr_a_in  in  14  PPU address.
- chr_r_nw_in  in  1  PPU read/write.
- chr_d_in  in  8  PPU write data.
- chr_d_out  out  8  CHR read data; 0 when chr_a_in[13]=1.
- chr_mem_a_out  out  CHR_AW  banked CHR memory address.
- chr_mem_d_in  in  8  CHR memory read data.
- chr_mem_we_out  out  1  CHR write enable: CHR_RAM & ~chr_a_in[13] & ~chr_r_nw_in.
- ciram_nce_out  out  1  ~chr_a_in[13].
- ciram_a10_out  out  1  nametable A10 per mirroring mode.

## Operation
- Registers:
  - shift sr[4:0]
  - count cnt[2:0]
  - control ctl[4:0]
  - chr0[4:0], chr1[4:0]
  - prg[3:0]
  - wr_q (write-active delayed by one cycle)
- Reset values: sr=0, cnt=0, ctl=5'h0C, chr0=chr1=0, prg=0, wr_q=0.
- Write event:
  - wa = ~prg_nce_in & ~prg_r_nw_in.
  - An event occurs when wa=1 and wr_q=0.
  - wr_q <= wa every cycle.
  - A multi-cycle write therefore counts once.
- On an event with prg_d_in[7]=1: sr<=0, cnt<=0, ctl<=ctl|5'h0C. Other registers are unchanged.
- On an event with prg_d_in[7]=0 and cnt<4: sr<={prg_d_in[0],sr[4:1]}, cnt<=cnt+1.
- On an event with prg_d_in[7]=0 and cnt==4:
  - Compute v={prg_d_in[0],sr[4:1]}. The first-written bit becomes v[0].
  - prg_a_in[14:13] selects the target: 0 writes ctl<=v, 1 writes chr0<=v, 2 writes chr1<=v, 3 writes prg<=v[3:0].
  - Then sr<=0, cnt<=0.
- Mirroring, ctl[1:0]:
  - 0: a10=0
  - 1: a10=1
  - 2 (vertical): a10=chr_a_in[10]
  - 3 (horizontal): a10=chr_a_in[11]
- PRG mapping, 16 KB bank index B, then prg_mem_a_out={B,prg_a_in[13:0]} truncated to PRG_AW:
  - ctl[3:2]=0/1: B={prg[3:1],prg_a_in[14]}.
  - ctl[3:2]=2: B = prg_a_in[14] ? prg : 0.
  - ctl[3:2]=3: B = prg_a_in[14] ? last bank : prg.
  - Last bank = all ones over PRG_AW-14 bits.
- CHR mapping, 4 KB bank index C, then chr_mem_a_out={C,chr_a_in[11:0]} truncated to CHR_AW:
  - ctl[4]=0: C={chr0[4:1],chr_a_in[12]}.
  - ctl[4]=1: C = chr_a_in[12] ? chr1 : chr0.
- Bank bits above the configured width are discarded, so bank numbers wrap modulo the bank count.
- Read data: prg_d_out = prg_mem_d_in & {8{~prg_nce_in}}; chr_d_out = chr_mem_d_in & {8{~chr_a_in[13]}}.

## Timing
- Register updates happen on the clock edge at which the event is detected. Mapping changes are visible on address outputs one cycle later.
- All address, a10 and enable outputs are combinational from inputs and registers; there is no pipeline latency. Data latency equals the external memory latency (1 cycle for BRAM).
- Reset mid-sequence: an asynchronous rst_n_in low immediately restores all reset values. Address outputs then reflect ctl=0x0C.
- A reset-bit write during a partial load discards the accumulated bits.
- Reads (prg_r_nw_in=1) never generate events. A write held across reset produces an event only after reset deasserts if wa=1 and wr_q=0.

## Test plan
- Reset, then read $C000 with PRG_AW=18 -> prg_mem_a_out=18'h3C000 (last bank fixed). $8000 -> 18'h00000.
- Write 5 single-cycle writes of bit0 = 1,0,1,0,0 to $E000 -> prg=4'h5. $8000 then maps to 18'h14000.
- 5 writes to $8000 loading ctl=5'h02, then chr_a_in=14'h2400 -> ciram_a10_out=1 and ciram_nce_out=0. Load ctl=5'h03 -> a10=chr_a_in[11].
- Hold one write for 3 cycles -> cnt increments once. Write 8'h80 after 3 bits -> cnt=0, ctl[3:2]=3.
- ctl[4]=1, chr0=5'h03, chr1=5'h1F: PPU $1000 -> chr_mem_a_out=17'h1F000, $0000 -> 17'h03000. With CHR_RAM=0, chr_mem_we_out stays 0 on PPU writes.
- Assert rst_n_in after 3 shift writes -> all registers return to reset values. The next 5 writes load cleanly.
